// File: rtl/multicycle_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_datapath
//  Description : Multicycle ARM-style datapath. One shared memory port serves
//                instruction fetch and data access through a ready/request
//                handshake. An internal phase sequencer
//                (FETCH/DECODE/EXEC/MEM/WB/WB2) owns all timing. Long
//                operations write both halves of a 2*WIDTH product.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_datapath #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] PC_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       RegSrc,
  input  logic [1:0]       ImmSrc,
  input  logic             ALUSrc,
  input  logic [1:0]       ALUControl,
  input  logic             MemtoReg,
  input  logic             RegW,
  input  logic             IsMem,
  input  logic             MemW,
  input  logic             Branch,
  input  logic             LongW,
  input  logic             CondEx,
  output logic [3:0]       ALUFlags,
  output logic             FlagsValid,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] Instr,
  output logic             MemReq,
  output logic [WIDTH-1:0] MemAdr,
  output logic             MemWrite,
  output logic [WIDTH-1:0] WriteData,
  input  logic [WIDTH-1:0] ReadData,
  input  logic             MemReady
);

  // Instruction fields are decoded from a view at least 32 bits wide so that
  // narrow configurations still see well-defined (zero) upper fields.
  localparam int XW = (WIDTH > 32) ? WIDTH : 32;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_WB2    = 3'd5
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] pc_q, instr_q, a_q, b_q, alu_out_q, alu_out2_q, data_q;
  logic [WIDTH-1:0] rf [0:15];

  logic [XW-1:0]    instr_x;
  logic [23:0]      ifield;
  logic             unused_instr_hi;
  logic [WIDTH-1:0] pc_plus4;
  logic [3:0]       ra1, ra2, wb_dst, wb2_dst;
  logic [WIDTH-1:0] rd1, rd2;
  logic [XW-1:0]    imm8_x, imm12_x, br_x, ext_x;
  logic [WIDTH-1:0] ext_imm, src_b, b_op, op_res;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] alu_result1, alu_result2, result;
  logic             flag_n, flag_z, flag_c, flag_v;
  logic             take_branch;

  assign instr_x         = XW'(instr_q);
  assign ifield          = instr_x[23:0];
  assign unused_instr_hi = ^instr_x[XW-1:24];

  assign pc_plus4 = pc_q + WIDTH'(4);

  // Register addressing; r15 reads as PC + 4, i.e. fetch address + 8.
  assign ra1     = RegSrc[0] ? 4'd15 : ifield[19:16];
  assign ra2     = RegSrc[1] ? ifield[15:12] : ifield[3:0];
  assign wb_dst  = ifield[15:12];
  assign wb2_dst = ifield[19:16];
  assign rd1     = (ra1 == 4'd15) ? pc_plus4 : rf[ra1];
  assign rd2     = (ra2 == 4'd15) ? pc_plus4 : rf[ra2];

  // Immediate extension: 00 zero-extended imm8, 01 zero-extended imm12,
  // 10 sign-extended word-aligned branch offset, 11 zero.
  assign imm8_x  = XW'(ifield[7:0]);
  assign imm12_x = XW'(ifield[11:0]);
  assign br_x    = XW'($signed({ifield[23:0], 2'b00}));

  // Immediate select
  always_comb begin
    ext_x = '0;
    case (ImmSrc)
      2'b00:   ext_x = imm8_x;
      2'b01:   ext_x = imm12_x;
      2'b10:   ext_x = br_x;
      default: ext_x = '0;
    endcase
  end

  assign ext_imm = ext_x[WIDTH-1:0];

  // ALU: 00 ADD, 01 SUB, 10 AND, 11 ORR. Long operations replace the low
  // result with the low half of the unsigned product and expose the high half.
  assign src_b = ALUSrc ? ext_imm : b_q;
  assign b_op  = ALUControl[0] ? ~src_b : src_b;
  assign sum   = {1'b0, a_q} + {1'b0, b_op} + {{WIDTH{1'b0}}, ALUControl[0]};
  assign prod  = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, src_b};

  // ALU operation select
  always_comb begin
    op_res = '0;
    case (ALUControl)
      2'b00, 2'b01: op_res = sum[WIDTH-1:0];
      2'b10:        op_res = a_q & src_b;
      default:      op_res = a_q | src_b;
    endcase
  end

  assign alu_result1 = LongW ? prod[WIDTH-1:0] : op_res;
  assign alu_result2 = prod[2*WIDTH-1:WIDTH];

  assign flag_n = alu_result1[WIDTH-1];
  assign flag_z = (alu_result1 == '0);
  assign flag_c = ~ALUControl[1] & sum[WIDTH];
  assign flag_v = ~ALUControl[1] & ~(a_q[WIDTH-1] ^ b_op[WIDTH-1])
                  & (a_q[WIDTH-1] ^ sum[WIDTH-1]);

  assign result      = MemtoReg ? data_q : alu_out_q;
  assign take_branch = Branch & CondEx;

  // Phase register
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Next-phase selection and memory/flag strobes
  always_comb begin
    state_next = state;
    MemReq     = 1'b0;
    MemAdr     = '0;
    MemWrite   = 1'b0;
    FlagsValid = 1'b0;
    case (state)
      S_FETCH: begin
        MemReq = 1'b1;
        MemAdr = pc_q;
        if (MemReady) state_next = S_DECODE;
      end
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        FlagsValid = 1'b1;
        if (take_branch)          state_next = S_FETCH;
        else if (IsMem & CondEx)  state_next = S_MEM;
        else if (RegW & CondEx)   state_next = S_WB;
        else                      state_next = S_FETCH;
      end
      S_MEM: begin
        MemReq   = 1'b1;
        MemAdr   = alu_out_q;
        MemWrite = MemW & CondEx;
        if (MemReady) state_next = MemW ? S_FETCH : S_WB;
      end
      S_WB:    state_next = LongW ? S_WB2 : S_FETCH;
      S_WB2:   state_next = S_FETCH;
      default: state_next = S_FETCH;
    endcase
  end

  // Architectural and pipeline-phase registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= PC_RESET;
      instr_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      alu_out_q  <= '0;
      alu_out2_q <= '0;
      data_q     <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (MemReady) begin
            instr_q <= ReadData;
            pc_q    <= pc_plus4;
          end
        end
        S_DECODE: begin
          a_q <= rd1;
          b_q <= rd2;
        end
        S_EXEC: begin
          alu_out_q  <= alu_result1;
          alu_out2_q <= alu_result2;
          if (take_branch) pc_q <= alu_result1;
        end
        S_MEM: begin
          if (MemReady && !MemW) data_q <= ReadData;
        end
        S_WB: begin
          if (wb_dst == 4'd15) pc_q <= result;
        end
        default: ;
      endcase
    end
  end

  // Register file: written only in WB/WB2; writes to r15 never land here
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (state == S_WB && wb_dst != 4'd15) begin
      rf[wb_dst] <= result;
    end else if (state == S_WB2 && wb2_dst != 4'd15) begin
      rf[wb2_dst] <= alu_out2_q;
    end
  end

  assign ALUFlags  = FlagsValid ? {flag_n, flag_z, flag_c, flag_v} : 4'b0000;
  assign PC        = pc_q;
  assign Instr     = instr_q;
  assign WriteData = b_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_datapath
//  Description : Directed self-checking bench for multicycle_datapath, with a
//                32-bit instance and a 16-bit instance that wraps its PC.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        reset32, reset16;
  logic [1:0]  RegSrc, ImmSrc, ALUControl;
  logic        ALUSrc, MemtoReg, RegW, IsMem, MemW, Branch, LongW, CondEx;
  logic [31:0] ReadData;
  logic        MemReady;
  logic        use16;

  logic [3:0]  flags32, flags16;
  logic        fv32, fv16, req32, req16, wr32, wr16;
  logic [31:0] pc32, instr32, adr32, wd32;
  logic [15:0] pc16, instr16, adr16, wd16, rdata16;

  logic [3:0]  o_flags;
  logic        o_fv, o_req, o_wr;
  logic [31:0] o_pc, o_instr, o_adr, o_wd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rdata16 = ReadData[15:0];

  multicycle_datapath #(.WIDTH(32), .PC_RESET(32'h0)) u_dut32 (
    .clk(clk), .reset(reset32), .RegSrc(RegSrc), .ImmSrc(ImmSrc),
    .ALUSrc(ALUSrc), .ALUControl(ALUControl), .MemtoReg(MemtoReg),
    .RegW(RegW), .IsMem(IsMem), .MemW(MemW), .Branch(Branch), .LongW(LongW),
    .CondEx(CondEx), .ALUFlags(flags32), .FlagsValid(fv32), .PC(pc32),
    .Instr(instr32), .MemReq(req32), .MemAdr(adr32), .MemWrite(wr32),
    .WriteData(wd32), .ReadData(ReadData), .MemReady(MemReady)
  );

  multicycle_datapath #(.WIDTH(16), .PC_RESET(16'hFFE8)) u_dut16 (
    .clk(clk), .reset(reset16), .RegSrc(RegSrc), .ImmSrc(ImmSrc),
    .ALUSrc(ALUSrc), .ALUControl(ALUControl), .MemtoReg(MemtoReg),
    .RegW(RegW), .IsMem(IsMem), .MemW(MemW), .Branch(Branch), .LongW(LongW),
    .CondEx(CondEx), .ALUFlags(flags16), .FlagsValid(fv16), .PC(pc16),
    .Instr(instr16), .MemReq(req16), .MemAdr(adr16), .MemWrite(wr16),
    .WriteData(wd16), .ReadData(rdata16), .MemReady(MemReady)
  );

  // Observe whichever instance is under test
  assign o_flags = use16 ? flags16 : flags32;
  assign o_fv    = use16 ? fv16    : fv32;
  assign o_req   = use16 ? req16   : req32;
  assign o_wr    = use16 ? wr16    : wr32;
  assign o_pc    = use16 ? {16'h0, pc16}    : pc32;
  assign o_instr = use16 ? {16'h0, instr16} : instr32;
  assign o_adr   = use16 ? {16'h0, adr16}   : adr32;
  assign o_wd    = use16 ? {16'h0, wd16}    : wd32;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input logic [1:0] rs, input logic [1:0] is, input logic as,
                     input logic [1:0] ac, input logic m2r, input logic rw,
                     input logic im, input logic mw, input logic br,
                     input logic lw, input logic ce);
    RegSrc = rs; ImmSrc = is; ALUSrc = as; ALUControl = ac; MemtoReg = m2r;
    RegW = rw; IsMem = im; MemW = mw; Branch = br; LongW = lw; CondEx = ce;
  endtask

  // FETCH phase: address must be the expected PC; ends in DECODE
  task automatic fetch(input logic [31:0] adr, input logic [31:0] ins);
    check("fetch_req", {31'b0, o_req}, 32'd1);
    check("fetch_adr", o_adr, adr);
    ReadData = ins; MemReady = 1'b1;
    step();
    MemReady = 1'b0; ReadData = '0;
  endtask

  // Data-processing: FETCH, DECODE, EXEC, WB
  task automatic dp(input logic [31:0] adr, input logic [31:0] ins);
    fetch(adr, ins);
    step(); step(); step();
  endtask

  // Store with no wait: FETCH, DECODE, EXEC, MEM
  task automatic store(input logic [31:0] adr, input logic [31:0] ins,
                       input logic [31:0] madr, input logic [31:0] wdata);
    fetch(adr, ins);
    step(); step();
    check("st_adr", o_adr, madr);
    check("st_we", {31'b0, o_wr}, 32'd1);
    check("st_data", o_wd, wdata);
    MemReady = 1'b1;
    step();
    MemReady = 1'b0;
  endtask

  // Load with a number of MEM wait cycles
  task automatic load(input logic [31:0] adr, input logic [31:0] ins,
                      input logic [31:0] madr, input logic [31:0] rdata,
                      input int waits);
    fetch(adr, ins);
    step(); step();
    for (int i = 0; i < waits; i++) begin
      check("ld_wait_adr", o_adr, madr);
      check("ld_wait_we", {31'b0, o_wr}, 32'd0);
      check("ld_wait_req", {31'b0, o_req}, 32'd1);
      step();
    end
    check("ld_adr", o_adr, madr);
    MemReady = 1'b1; ReadData = rdata;
    step();
    MemReady = 1'b0; ReadData = '0;
    check("ld_wb_req", {31'b0, o_req}, 32'd0);
    step();
  endtask

  initial begin
    use16 = 1'b0; reset32 = 1'b1; reset16 = 1'b1;
    MemReady = 1'b0; ReadData = '0;
    ctl(2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); step();
    reset32 = 1'b0;

    // Reset state
    check("rst_req", {31'b0, o_req}, 32'd1);
    check("rst_adr", o_adr, 32'h0);
    check("rst_we", {31'b0, o_wr}, 32'd0);
    check("rst_fv", {31'b0, o_fv}, 32'd0);
    check("rst_pc", o_pc, 32'h0);
    check("rst_instr", o_instr, 32'h0);

    // r0 = r0 + 5 ; r1 = r0 + 2 ; r2 = r0 + r1
    ctl(2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    dp(32'h0, 32'h0000_0005);
    check("pc_after_add", o_pc, 32'h4);
    dp(32'h4, 32'h0000_1002);
    ctl(2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    fetch(32'h8, 32'h0000_2001);
    step();
    check("exec_fv", {31'b0, o_fv}, 32'd1);
    check("exec_flags", {28'b0, o_flags}, 32'h0);
    step(); step();

    // STR r2, [r0, #0x40]
    ctl(2'b10, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    store(32'hC, 32'h0000_2040, 32'h45, 32'd12);

    // r0 = r7 + 0x100
    ctl(2'b00, 2'b01, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    dp(32'h10, 32'h0007_0100);

    // LDR r3, [r0, #8] with three wait cycles
    ctl(2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    load(32'h14, 32'h0000_3008, 32'h108, 32'hCAFE_F00D, 3);

    // STR r3, [r0] exposes the loaded value
    ctl(2'b10, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    store(32'h18, 32'h0000_3000, 32'h100, 32'hCAFE_F00D);

    // STR with condition failed: three cycles, never writes
    ctl(2'b10, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    fetch(32'h1C, 32'h0000_2004);
    check("cf_dec_we", {31'b0, o_wr}, 32'd0);
    step();
    check("cf_exec_we", {31'b0, o_wr}, 32'd0);
    check("cf_exec_req", {31'b0, o_req}, 32'd0);
    step();

    // B +0x10 at 0x20 -> 0x38
    ctl(2'b01, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    fetch(32'h20, 32'h0000_0004);
    step(); step();
    check("br_pc", o_pc, 32'h38);

    // LDR r5, [r0] = 0x00010001
    ctl(2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    load(32'h38, 32'h0000_5000, 32'h100, 32'h0001_0001, 0);

    // Long: {r5, r4} = r5 * r3 = 0x10001 * 0xCAFEF00D
    ctl(2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    fetch(32'h3C, 32'h0005_4003);
    step(); step(); step(); step();

    ctl(2'b10, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    store(32'h40, 32'h0000_4000, 32'h100, 32'hBB0B_F00D);
    store(32'h44, 32'h0000_5000, 32'h100, 32'h0000_CAFF);

    // Reset during a stalled store
    fetch(32'h48, 32'h0000_2000);
    step(); step();
    check("mw_we", {31'b0, o_wr}, 32'd1);
    check("mw_data", o_wd, 32'd12);
    step();
    check("mw_hold_adr", o_adr, 32'h100);
    reset32 = 1'b1;
    step();
    reset32 = 1'b0;
    check("mrst_req", {31'b0, o_req}, 32'd1);
    check("mrst_we", {31'b0, o_wr}, 32'd0);
    check("mrst_adr", o_adr, 32'h0);
    check("mrst_pc", o_pc, 32'h0);

    // 16-bit instance, PC starting near the top of the address space
    use16 = 1'b1;
    reset32 = 1'b1;
    step();
    reset16 = 1'b0;
    check("r16_adr", o_adr, 32'hFFE8);
    check("r16_we", {31'b0, o_wr}, 32'd0);
    ctl(2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    dp(32'hFFE8, 32'h0005);
    check("w16_pc", o_pc, 32'hFFEC);
    dp(32'hFFEC, 32'h1002);
    ctl(2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    dp(32'hFFF0, 32'h2001);
    ctl(2'b10, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    store(32'hFFF4, 32'h2040, 32'h45, 32'd12);
    // Branch at 0xFFF8: 0xFFF8 + 8 + 0x10 wraps to 0x0010
    ctl(2'b01, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    fetch(32'hFFF8, 32'h0004);
    check("w16_br_fetch_pc", o_pc, 32'hFFFC);
    step(); step();
    check("w16_br_pc", o_pc, 32'h0010);
    check("w16_br_adr", o_adr, 32'h0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_datapath.md
# multicycle_datapath

Parametrised multicycle successor to the single-cycle ARM datapath. It shares one memory port between instruction fetch and data access, and holds an internal phase sequencer (FETCH/DECODE/EXEC/MEM/WB/WB2) with a ready/request memory handshake. It also writes back both halves of a long ALU result (ALUResult1/ALUResult2). The decoder/controller supplies per-instruction class and control bits combinationally from the `Instr` output; the block owns all timing.

## Interface
- WIDTH, 32, datapath/register/memory word width (≥ 8, multiple of 8)
- PC_RESET, 0, PC value loaded on reset
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- RegSrc  in  2  [0]: RA1 = 15; [1]: RA2 = Instr[15:12]
- ImmSrc  in  2  extend mode, same encoding as the existing extend unit
- ALUSrc  in  1  SrcB = ExtImm when 1, else B register
- ALUControl  in  2  ALU operation
- MemtoReg  in  1  WB writes data register (1) or ALUOut (0)
- RegW, IsMem, MemW, Branch, LongW  in  1 each  instruction class bits
- CondEx  in  1  condition passed; sampled in EXEC and MEM
- ALUFlags  out  4  ALU NZCV, valid only while FlagsValid = 1
- FlagsValid  out  1  high in EXEC
- PC  out  WIDTH  current PC
- Instr  out  WIDTH  instruction register
- MemReq  out  1  memory request
- MemAdr  out  WIDTH  PC in FETCH, ALUOut in MEM, else 0
- MemWrite  out  1  MEM & MemW & CondEx
- WriteData  out  WIDTH  B register
- ReadData  in  WIDTH  memory read data
- MemReady  in  1  completes current request this cycle

## Operation
- Registers: PC, Instr, A, B, ALUOut, ALUOut2, Data, state. Register file: 16 × WIDTH; a read of r15 returns PC + 4. Since PC is already incremented, this equals fetch address + 8.
- FETCH: MemReq = 1, MemAdr = PC. On MemReady: Instr ← ReadData, PC ← PC + 4 (mod 2^WIDTH), go to DECODE. Otherwise hold.
- DECODE: A ← rf[RA1], B ← rf[RA2]; go to EXEC.
- EXEC: ALUOut ← ALUResult1, ALUOut2 ← ALUResult2. Next state:
  - Branch & CondEx: PC ← ALUResult1, go to FETCH.
  - IsMem & CondEx: go to MEM.
  - RegW & CondEx: go to WB.
  - Otherwise: go to FETCH.
- MEM: MemReq = 1, MemAdr = ALUOut, MemWrite = MW. On MemReady:
  - Load: Data ← ReadData, go to WB.
  - Store: go to FETCH.
  - Otherwise: hold, with all outputs stable.
- WB: rf[Instr[15:12]] ← Result, where Result = MemtoReg ? Data : ALUOut.
  - If Instr[15:12] = 15: PC ← Result, no register write.
  - Next state: LongW ? WB2 : FETCH.
- WB2: rf[Instr[19:16]] ← ALUOut2, go to FETCH. If Instr[19:16] = 15, the write is dropped.
- The register file is written only in WB/WB2. MemReq is never high outside FETCH/MEM. MemWrite is never high without MemReq.
- Arithmetic: all PC math is WIDTH-bit unsigned and wraps. ExtImm is WIDTH bits; the branch offset is sign-extended to WIDTH.

## Timing
- Reset: state = FETCH, PC = PC_RESET; Instr, A, B, ALUOut, ALUOut2, Data = 0.
  - Output values the cycle after reset: MemReq = 1, MemAdr = PC_RESET, MemWrite = 0, FlagsValid = 0.
- Reset in any state, including during a MEM wait, overrides all transitions. An in-flight store does not complete; memory sees the request drop or change address.
- Cycles per instruction with MemReady tied high:
  - Data-processing: 4
  - Load: 5
  - Store: 4
  - Taken branch: 3
  - Long result: 5
  - Condition failed: 3
- Each cycle MemReady is low adds one cycle.
- MemReady outside FETCH/MEM is ignored.
- A taken branch in EXEC lands on the next PC at the EXEC→FETCH edge. The first fetch at the target address starts the following cycle.
- A register written in WB is readable in the next instruction's DECODE; there are no hazards.

## Test plan
- Reset for 2 cycles, then MemReady = 1, ReadData = ADD (RegW, Rd = 2, r0 = 5, r1 = 7) -> MemAdr = 0 in FETCH; r2 = 12 after 4 cycles; PC = 4.
- LDR r3, [r0, #8] with r0 = 0x100 and MemReady low for 3 MEM cycles -> MemAdr = 0x108 held with MemWrite = 0; r3 = ReadData; 8 cycles total.
- STR with CondEx = 0 in EXEC -> state goes EXEC→FETCH; MemWrite is never asserted; CPI = 3.
- Branch at PC = 0x20 with offset +0x10 -> next fetch MemAdr = 0x20 + 8 + 0x10 = 0x38; CPI = 3.
- LongW with ALUResult1 = 0x89ABCDEF, ALUResult2 = 0x01234567, Rd = 4, Rn = 5 -> r4 = 0x89ABCDEF, r5 = 0x01234567 in consecutive cycles; CPI = 5.
- Reset asserted mid-MEM wait of a store -> next cycle state = FETCH, MemWrite = 0, MemAdr = PC_RESET.
- Repeat the ADD and branch scenarios with WIDTH = 16, including a branch that wraps the PC past 0xFFFC.
